// File: rtl/scan_sequencer.sv
// Ascending channel scanner for a 3-to-8 decoder: holds each enabled channel for a
// programmable dwell, then blanks en for BLANK_CYC cycles before moving on.
module scan_sequencer #(
    parameter int DWELL_W   = 8,
    parameter int BLANK_CYC = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               continuous,
    input  logic [7:0]         chan_mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         sel,
    output logic               en,
    output logic               busy,
    output logic               frame_done
);
    localparam int BLANK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam int CNT_W   = (DWELL_W > BLANK_W) ? DWELL_W : BLANK_W;
    localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CYC > 0) ? CNT_W'(BLANK_CYC - 1) : '0;

    typedef enum logic [1:0] {IDLE, DWELL, BLANK} state_t;

    state_t             state, state_nx;
    logic [2:0]         ch, ch_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [7:0]         mask_l, mask_nx;
    logic [DWELL_W-1:0] dwell_l, dwell_nx, dwell_last;
    logic               done_nx, en_nx, busy_nx;
    logic [2:0]         sel_nx;
    logic [3:0]         first, above;
    logic               step;

    // {found, index} of the lowest set bit
    function automatic logic [3:0] lowest(input logic [7:0] m);
        logic [3:0] r;
        r = '0;
        for (int i = 7; i >= 0; i--)
            if (m[i]) r = {1'b1, 3'(i)};
        return r;
    endfunction

    // {found, index} of the lowest set bit strictly above channel c
    function automatic logic [3:0] next_above(input logic [7:0] m, input logic [2:0] c);
        logic [3:0] r;
        r = '0;
        for (int i = 7; i >= 0; i--)
            if (m[i] && (i > int'(c))) r = {1'b1, 3'(i)};
        return r;
    endfunction

    assign dwell_last = (dwell_l == '0) ? '0 : dwell_l - DWELL_W'(1);
    assign first      = lowest(chan_mask);
    assign above      = next_above(mask_l, ch);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ch      <= '0;
            cnt     <= '0;
            mask_l  <= '0;
            dwell_l <= '0;
        end else begin
            state   <= state_nx;
            ch      <= ch_nx;
            cnt     <= cnt_nx;
            mask_l  <= mask_nx;
            dwell_l <= dwell_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ch_nx    = ch;
        cnt_nx   = cnt;
        mask_nx  = mask_l;
        dwell_nx = dwell_l;
        done_nx  = 1'b0;
        step     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop && (chan_mask != '0)) begin
                    mask_nx  = chan_mask;
                    dwell_nx = dwell;
                    ch_nx    = first[2:0];
                    cnt_nx   = '0;
                    state_nx = DWELL;
                end
            end
            DWELL: begin
                if (cnt == CNT_W'(dwell_last)) begin
                    if (BLANK_CYC == 0) begin
                        step = 1'b1;
                    end else begin
                        state_nx = BLANK;
                        cnt_nx   = '0;
                    end
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            BLANK: begin
                if (cnt == BLANK_LAST) step = 1'b1;
                else                   cnt_nx = cnt + CNT_W'(1);
            end
            default: state_nx = IDLE;
        endcase

        if (step) begin
            cnt_nx = '0;
            if (above[3]) begin
                ch_nx    = above[2:0];
                state_nx = DWELL;
            end else begin
                done_nx = 1'b1;
                // Frame wrap relatches the live inputs for the next frame
                if (continuous && (chan_mask != '0)) begin
                    mask_nx  = chan_mask;
                    dwell_nx = dwell;
                    ch_nx    = first[2:0];
                    state_nx = DWELL;
                end else begin
                    ch_nx    = '0;
                    state_nx = IDLE;
                end
            end
        end

        if (stop && (state != IDLE)) begin
            state_nx = IDLE;
            ch_nx    = '0;
            cnt_nx   = '0;
            done_nx  = 1'b0;
        end
    end

    always_comb begin
        en_nx   = (state_nx == DWELL);
        busy_nx = (state_nx != IDLE);
        sel_nx  = (state_nx == IDLE) ? 3'd0 : ch_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel        <= '0;
            en         <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            sel        <= sel_nx;
            en         <= en_nx;
            busy       <= busy_nx;
            frame_done <= done_nx;
        end
    end
endmodule
